// File: rtl/regfile_mp_sb_if.sv
// Port bundle for the multi-port register file: read ports, two write ports,
// scoreboard controls and the registered status outputs.
interface regfile_mp_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr0_en;
  logic [ADDR_W-1:0]        wr0_addr;
  logic [DATA_W-1:0]        wr0_data;
  logic                     wr1_en;
  logic [ADDR_W-1:0]        wr1_addr;
  logic [DATA_W-1:0]        wr1_data;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;
  logic                     flush;
  logic [DEPTH-1:0]         pending;
  logic                     wr_conflict;

  modport master (
    output rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
           rsv_en, rsv_addr, flush,
    input  rd_data, rd_busy, pending, wr_conflict
  );

  modport slave (
    input  rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
           rsv_en, rsv_addr, flush,
    output rd_data, rd_busy, pending, wr_conflict
  );
endinterface

// File: rtl/regfile_mp_sb.sv
// NUM_RD-read / 2-write register file with optional write-to-read bypass and a
// per-register pending scoreboard for load-use and multicycle hazard stalls.
module regfile_mp_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input logic            clock,
  input logic            reset,
  regfile_mp_sb_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
    $error("regfile_mp_sb: NUM_RD must be in 1..4");
  end
  if ($bits(bus.rd_addr) != NUM_RD * ADDR_W || $bits(bus.rd_data) != NUM_RD * DATA_W) begin : g_bad_bus
    $error("regfile_mp_sb: interface parameters do not match the module");
  end

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pend_q;
  logic [DEPTH-1:0]  pend_d;
  logic              conflict_q;
  logic              wr0_ok;
  logic              wr1_ok;
  logic              wr0_commit;
  logic              same_addr;
  logic              rsv_ok;

  // Writes (and reservations) to r0 are dropped when r0 is hardwired.
  always_comb begin
    wr0_ok     = bus.wr0_en && !((ZERO_REG != 0) && (bus.wr0_addr == '0));
    wr1_ok     = bus.wr1_en && !((ZERO_REG != 0) && (bus.wr1_addr == '0));
    rsv_ok     = bus.rsv_en && !((ZERO_REG != 0) && (bus.rsv_addr == '0));
    same_addr  = (bus.wr0_addr == bus.wr1_addr);
    wr0_commit = wr0_ok && !(wr1_ok && same_addr);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (wr0_commit) regs[bus.wr0_addr] <= bus.wr0_data;
      if (wr1_ok)     regs[bus.wr1_addr] <= bus.wr1_data;
    end
  end

  // Clear, then set (a new reservation supersedes the returning write), then flush.
  always_comb begin
    pend_d = pend_q;
    if (bus.wr1_en) pend_d[bus.wr1_addr] = 1'b0;
    if (rsv_ok)     pend_d[bus.rsv_addr] = 1'b1;
    if (bus.flush)  pend_d = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      conflict_q <= wr0_ok && wr1_ok && same_addr;
    end
  end

  assign bus.pending     = pend_q;
  assign bus.wr_conflict = conflict_q;

  // Read mux; reset forces zero so bypassed write data cannot leak out while held.
  always_comb begin
    logic [ADDR_W-1:0] a;
    logic              hit0;
    logic              hit1;
    bus.rd_data = '0;
    bus.rd_busy = '0;
    a    = '0;
    hit0 = 1'b0;
    hit1 = 1'b0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      a    = bus.rd_addr[i*ADDR_W +: ADDR_W];
      hit1 = (BYPASS != 0) && bus.wr1_en && (bus.wr1_addr == a);
      hit0 = (BYPASS != 0) && bus.wr0_en && (bus.wr0_addr == a);
      if (reset || ((ZERO_REG != 0) && (a == '0))) begin
        bus.rd_data[i*DATA_W +: DATA_W] = '0;
      end else if (hit1) begin
        bus.rd_data[i*DATA_W +: DATA_W] = bus.wr1_data;
      end else if (hit0) begin
        bus.rd_data[i*DATA_W +: DATA_W] = bus.wr0_data;
      end else begin
        bus.rd_data[i*DATA_W +: DATA_W] = regs[a];
      end
      bus.rd_busy[i] = pend_q[a] && !hit1;
    end
  end
endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
Parametrised multi-port successor to the single-write MIPS register file. It provides NUM_RD asynchronous read ports and two synchronous write ports: wr0 for ALU writeback and wr1 for load/multicycle return. It adds optional write-to-read bypass and a per-register pending scoreboard, which the hazard unit uses for load-use and multicycle stalls. It sits in the decode stage, in place of the 2R1W file.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
NUM_RD, 2, number of read ports (1..4)
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads see array only
ZERO_REG, 1, 1 = register 0 hardwired to zero (reads 0, writes and reservations ignored)

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
rd_addr  in  NUM_RD*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  read data; port i at bits [i*DATA_W +: DATA_W]
rd_busy  out  NUM_RD  port i's register has a reservation not yet resolved
wr0_en  in  1  write enable, port 0 (ALU)
wr0_addr  in  ADDR_W  write address, port 0
wr0_data  in  DATA_W  write data, port 0
wr1_en  in  1  write enable, port 1 (load/multicycle return)
wr1_addr  in  ADDR_W  write address, port 1
wr1_data  in  DATA_W  write data, port 1
rsv_en  in  1  reserve (mark pending) rsv_addr at this edge
rsv_addr  in  ADDR_W  register to reserve
flush  in  1  clear all pending bits (pipeline squash)
pending  out  DEPTH  registered pending-bit vector
wr_conflict  out  1  registered; wr0 and wr1 hit the same non-ignored address last cycle

Behaviour:
- Reset (async, any time, including mid-operation):
  - all registers, pending and wr_conflict go to 0 immediately.
  - rd_data therefore reads 0 and rd_busy reads 0 while reset is held.
- Writes:
  - On posedge clock, wrN_en commits wrN_data to wrN_addr.
  - With ZERO_REG=1, a write to address 0 is ignored.
- Write collision: if wr0_en && wr1_en && wr0_addr==wr1_addr (and the address is not ignored):
  - wr1 wins and wr0's data is dropped.
  - wr_conflict=1 on the following cycle. It holds 1 for exactly one cycle per collision cycle.
- Reads (combinational, zero latency), port i in priority order:
  - (a) ZERO_REG && addr==0 gives 0.
  - (b) BYPASS && wr1_en && wr1_addr==addr gives wr1_data.
  - (c) BYPASS && wr0_en && wr0_addr==addr gives wr0_data.
  - (d) otherwise the array value.
  - With BYPASS=0, the new value is visible the cycle after the write.
- Scoreboard, per register a, at posedge:
  - set when rsv_en && rsv_addr==a.
  - cleared when wr1_en && wr1_addr==a.
  - Simultaneous set and clear on the same a: set wins (a new reservation supersedes the returning one).
  - flush clears every bit and overrides a same-cycle rsv_en (a squashed instruction's reservation is discarded).
  - A wr1 that arrives after a flush still writes data normally.
  - wr0 never changes pending.
  - With ZERO_REG=1, bit 0 is never set.
- rd_busy[i] = pending[rd_addr_i] && !(BYPASS && wr1_en && wr1_addr==rd_addr_i). The returning write resolves the hazard in the same cycle. With BYPASS=0, busy stays high until the cycle after the wr1 write.
- Reservation of an already-pending register: the bit stays 1. There is no counting; one wr1 clears it.
- Out-of-range NUM_RD is a configuration error; elaboration must fail.

Test Plan:
- Reset then read: assert reset mid-cycle after writing 0xDEADBEEF to r5 -> rd_data for r5 = 0, pending = 0, wr_conflict = 0 immediately; after release, r5 still reads 0.
- Bypass: BYPASS=1, wr0 r7=0x11 while port 0 reads r7 -> rd_data0=0x11 in the same cycle. Repeat with BYPASS=0 -> old value (0) that cycle, then 0x11 the next cycle.
- Collision: wr0 r3=0xAAAA and wr1 r3=0x5555 in one cycle -> r3 reads 0x5555 afterwards, wr_conflict=1 for one cycle then 0. Repeat with both writes to r0 -> no conflict, r0 reads 0.
- Load-use scoreboard: rsv r9; next cycle port 1 reads r9 -> rd_busy[1]=1. Three cycles later wr1 r9=0x1234 -> rd_busy[1]=0 and rd_data1=0x1234 in that cycle; pending[9]=0 afterwards.
- Set/clear race: pending r4, then in one cycle rsv r4 plus wr1 r4=0x77 -> r4=0x77, pending[4] stays 1.
- Flush: reserve r2, r6 and r31, then flush with rsv_en r8 in the same cycle -> pending all 0. A later wr1 to r6=0x99 writes 0x99 and pending stays 0.
